truth_sweep_ctrl: RTL and testbench

//  Self-test sequencer for the 4-input combinational logic block (inputs a,b,c,d; output y).
//  On start, drives all 16 input vectors in order, from abcd=0000 to 1111 (a = MSB).
//  For each vector it waits a settle time, samples y, and records it in a truth vector.

---
 rtl/truth_sweep_pkg.sv | 27 ++
 rtl/sweep_settle_timer.sv | 29 ++
 rtl/truth_sweep_ctrl.sv | 171 +++++++++++++++++
 tb/tb_truth_sweep_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/truth_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package truth_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VEC = 16;
  localparam int IDX_W   = 4;
  localparam int CNT_W   = 5;
  localparam int TMR_W   = 8;

  // Golden truth table of y = a'b' + b'd' + acd', bit i = y for abcd=i.
  localparam logic [NUM_VEC-1:0] GOLDEN = 16'h450F;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

  // The timer reports expiry on the cycle its count reaches zero, so a
  // hold of N cycles needs a load value of N-1.
  function automatic logic [TMR_W-1:0] settle_load(input int settle_cyc);
    return TMR_W'(settle_cyc - 1);
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// Load/expire down-counter that times how long each vector is held.
module sweep_settle_timer
  import truth_sweep_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_expired
);

  logic [W-1:0] r_cnt;

  // Count down from the loaded value and park at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/truth_sweep_ctrl.sv
// Self-test sequencer: sweeps abcd over 0..15, samples y after a settle
// time, and compares the captured truth table against an expected one.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep are held
// DRIVE  | abcd = idx is applied, waiting for the settle timer
// SAMPLE | y_in captured into truth[idx] and compared
// DONE   | one-cycle done pulse; pass reflects the completed sweep
module truth_sweep_ctrl
  import truth_sweep_pkg::*;
#(
  parameter logic [NUM_VEC-1:0] EXPECTED   = GOLDEN,
  parameter int                 SETTLE_CYC = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  output logic               o_a,
  output logic               o_b,
  output logic               o_c,
  output logic               o_d,
  input  logic               i_y_in,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic [NUM_VEC-1:0] o_truth,
  output logic [CNT_W-1:0]   o_fail_count,
  output logic [IDX_W-1:0]   o_first_fail_idx
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_VEC-1:0] r_truth;
  logic [CNT_W-1:0]   r_fail_count;
  logic [IDX_W-1:0]   r_first_fail_idx;
  logic               r_pass;

  logic w_busy;
  logic w_done;
  logic w_start_acc;
  logic w_abort_acc;
  logic w_capture;
  logic w_tmr_load;
  logic w_tmr_expired;
  logic w_last;
  logic w_mismatch;

  assign w_last     = (r_idx == LAST_IDX);
  assign w_mismatch = (i_y_in != EXPECTED[r_idx]);

  sweep_settle_timer #(
    .W(TMR_W)
  ) u_settle (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_tmr_load),
    .i_load_val(settle_load(SETTLE_CYC)),
    .o_expired (w_tmr_expired)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; abort wins over the settle timer and the sample step.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = DRIVE;
      end
      DRIVE: begin
        if (i_abort)            w_state_nxt = IDLE;
        else if (w_tmr_expired) w_state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (i_abort)     w_state_nxt = IDLE;
        else if (w_last) w_state_nxt = DONE;
        else             w_state_nxt = DRIVE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State-derived outputs and datapath strobes.
  always_comb begin
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_start_acc = 1'b0;
    w_abort_acc = 1'b0;
    w_capture   = 1'b0;
    w_tmr_load  = 1'b0;
    case (r_state)
      IDLE: begin
        w_start_acc = i_start;
        w_tmr_load  = i_start;
      end
      DRIVE: begin
        w_busy      = 1'b1;
        w_abort_acc = i_abort;
      end
      SAMPLE: begin
        w_busy      = 1'b1;
        w_abort_acc = i_abort;
        w_capture   = ~i_abort;
        w_tmr_load  = ~i_abort & ~w_last;
      end
      DONE: begin
        w_done = 1'b1;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Index, capture and compare; pass is settled on the edge into DONE so it
  // is already valid alongside the done pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx            <= '0;
      r_truth          <= '0;
      r_fail_count     <= '0;
      r_first_fail_idx <= '0;
      r_pass           <= 1'b0;
    end else if (w_start_acc) begin
      r_idx            <= '0;
      r_truth          <= '0;
      r_fail_count     <= '0;
      r_first_fail_idx <= '0;
      r_pass           <= 1'b0;
    end else if (w_abort_acc) begin
      r_idx  <= '0;
      r_pass <= 1'b0;
    end else if (w_capture) begin
      r_truth[r_idx] <= i_y_in;
      if (w_mismatch) begin
        r_fail_count <= r_fail_count + 1'b1;
        if (r_fail_count == '0) r_first_fail_idx <= r_idx;
      end
      if (w_last) begin
        r_pass <= (r_fail_count == '0) && !w_mismatch;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // The stimulus is the registered index itself; after DONE it stays at 1111.
  assign {o_a, o_b, o_c, o_d} = r_idx;

  assign o_busy           = w_busy;
  assign o_done           = w_done;
  assign o_pass           = r_pass;
  assign o_truth          = r_truth;
  assign o_fail_count     = r_fail_count;
  assign o_first_fail_idx = r_first_fail_idx;

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Bench for truth_sweep_ctrl: a behavioural model of the logic block under
// test drives y_in, expected sweep results go into a scoreboard queue, and a
// monitor compares them whenever done pulses.
module tb_truth_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic        a, b, c, d;
  logic        y_in;
  logic        busy, done, pass;
  logic [15:0] truth;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail_idx;

  int mode;       // 0 = correct block, 1 = y stuck at 0, 2 = vector 14 inverted
  int cyc = 0;    // number of rising edges so far
  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;

  typedef struct {
    logic [15:0] truth;
    int          fc;
    int          ffi;
    logic        pass;
    int          done_edge;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  truth_sweep_ctrl #(
    .EXPECTED  (16'h450F),
    .SETTLE_CYC(2)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_start         (start),
    .i_abort         (abort),
    .o_a             (a),
    .o_b             (b),
    .o_c             (c),
    .o_d             (d),
    .i_y_in          (y_in),
    .o_busy          (busy),
    .o_done          (done),
    .o_pass          (pass),
    .o_truth         (truth),
    .o_fail_count    (fail_count),
    .o_first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic block_model(input int m, input logic [3:0] v);
    logic va, vb, vc, vd, y;
    {va, vb, vc, vd} = v;
    y = (~va & ~vb) | (~vb & ~vd) | (va & vc & ~vd);
    if (m == 1) return 1'b0;
    if (m == 2 && v == 4'd14) return ~y;
    return y;
  endfunction

  assign y_in = block_model(mode, {a, b, c, d});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_abcd"}, {28'd0, a, b, c, d}, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_truth"}, 32'(truth), 32'd0);
    check({tag, "_fail_count"}, 32'(fail_count), 32'd0);
    check({tag, "_first_fail_idx"}, 32'(first_fail_idx), 32'd0);
  endtask

  // Pulse start for one edge; k is the edge that registers it.
  task automatic start_sweep(output int k);
    @(negedge clk);
    start = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Done is expected in the 49th cycle after the start edge, i.e. it is seen
  // at the falling edge that follows rising edge k+48.
  task automatic push_exp(input int k, input logic [15:0] t, input int fc, input int ffi, input logic p);
    exp_t e;
    e.truth     = t;
    e.fc        = fc;
    e.ffi       = ffi;
    e.pass      = p;
    e.done_edge = k + 48;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int prev, input string tag);
    int t;
    t = 0;
    while (done_cnt == prev && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt != prev), 32'd1);
  endtask

  task automatic wait_edge(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic run_full(input string tag, input int m, input logic [15:0] t,
                          input int fc, input int ffi, input logic p);
    int k;
    int prev;
    mode = m;
    prev = done_cnt;
    start_sweep(k);
    push_exp(k, t, fc, ffi, p);
    wait_done(prev, tag);
    @(negedge clk);
    check({tag, "_pass_held"}, 32'(pass), 32'(p));
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_abcd_1111"}, {28'd0, a, b, c, d}, 32'hF);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      check("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("sb_done_edge", 32'(cyc), 32'(mon_e.done_edge));
        check("sb_truth", 32'(truth), 32'(mon_e.truth));
        check("sb_fail_count", 32'(fail_count), 32'(mon_e.fc));
        check("sb_pass", 32'(pass), 32'(mon_e.pass));
        if (mon_e.fc != 0) check("sb_first_fail_idx", 32'(first_fail_idx), 32'(mon_e.ffi));
      end
    end
  end

  initial begin
    int k;
    int prev;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("idle");

    // Correct block: full pass.
    run_full("golden", 0, 16'h450F, 0, 0, 1'b1);

    // y stuck at 0: the seven 1-entries of the golden table all mismatch.
    run_full("stuck0", 1, 16'h0000, 7, 0, 1'b0);

    // Only abcd=1110 wrong.
    run_full("inv14", 2, 16'h050F, 1, 14, 1'b0);

    // Abort landing on rising edge k+20: vectors 0..5 were sampled at edges
    // k+3..k+18; with y stuck at 0 vectors 0..3 mismatch.
    mode = 1;
    prev = done_cnt;
    start_sweep(k);
    wait_edge(k + 19);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_abcd", {28'd0, a, b, c, d}, 32'd0);
    check("abort_pass", 32'(pass), 32'd0);
    check("abort_truth", 32'(truth), 32'h0000);
    check("abort_fail_count", 32'(fail_count), 32'd4);
    check("abort_first_fail_idx", 32'(first_fail_idx), 32'd0);
    repeat (60) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(prev));
    run_full("after_abort", 0, 16'h450F, 0, 0, 1'b1);

    // start while busy and in the DONE cycle: one done, same timing.
    mode = 0;
    prev = done_cnt;
    start_sweep(k);
    push_exp(k, 16'h450F, 0, 0, 1'b1);
    wait_edge(k + 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_edge(k + 48);
    check("dup_done_cycle", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_in_done_ignored", 32'(busy), 32'd0);
    repeat (60) @(negedge clk);
    check("dup_single_done", 32'(done_cnt), 32'(prev + 1));

    // Reset on edge k+30 mid-sweep with failures already recorded.
    mode = 1;
    start_sweep(k);
    wait_edge(k + 29);
    check("pre_rst_fail_count", 32'(fail_count != 0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midrst");
    run_full("after_rst", 0, 16'h450F, 0, 0, 1'b1);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
